led_pulse_stretch: RTL and testbench
====================================

Name: led_pulse_stretch

Overview:
- Output-side companion to the button input sampler: converts single-cycle internal events into blinks long enough for a person to see on the board LEDs.
- Each accepted event produces one blink of HOLD_CYCLES cycles, followed by a mandatory dark gap of GAP_CYCLES cycles.
- Events that arrive during a blink or gap are queued in a saturating pending counter, so every event yields a distinct visible blink until the queue overflows.

Parameters:
- HOLD_CYCLES, 16, LED on-time per blink in clock cycles; must be >= 1.
- GAP_CYCLES, 8, LED off-time after each blink in clock cycles; must be >= 1.
- CNT_W, 5, width of the internal down-counter; must hold max(HOLD_CYCLES, GAP_CYCLES) - 1.
- PEND_W, 3, width of the pending-event counter; maximum queued count is 2^PEND_W - 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- in  input  1  event strobe; each high cycle is one event.
- clear  input  1  synchronous flush; active high.
- out  output  1  LED drive, registered.
- busy  output  1  high whenever state is not IDLE.
- pending  output  PEND_W  number of queued events, registered.
- overflow  output  1  sticky flag: at least one event was dropped.

Behaviour:
- Reset and clock: reset is asynchronous, active-low (reset); clock is clock.
- Reset values: out=0, busy=0, pending=0, overflow=0, state=IDLE, timer=0.
- Priority order: reset > clear > normal operation.
- clear=1 on a rising edge: state returns to IDLE; out, pending and overflow go to 0; any in that cycle is discarded.
- States: IDLE, ON, GAP. busy is decoded from the registered state.
- IDLE:
  - out=0.
  - If in=1 or pending>0: go to ON and load timer=HOLD_CYCLES-1.
  - Latency: in high at edge t gives out high from edge t+1.
- ON:
  - out=1.
  - Timer decrements each cycle.
  - When timer==0: go to GAP and load timer=GAP_CYCLES-1.
  - out is high for exactly HOLD_CYCLES cycles.
- GAP:
  - out=0.
  - Timer decrements each cycle.
  - When timer==0: if pending>0 or in=1, go to ON with timer=HOLD_CYCLES-1; otherwise go to IDLE.
  - out is low for exactly GAP_CYCLES cycles before the next blink.
- Launch point: any IDLE->ON or GAP->ON transition. Exactly one event is consumed there.
  - If pending>0, the queued event is consumed; pending decrements, and any simultaneous in increments it, so net change is 0.
  - If pending==0, the in event is consumed directly; pending is unchanged.
- Non-launch cycles: in=1 increments pending.
  - If pending is already 2^PEND_W-1, the event is dropped and overflow is set to 1.
  - overflow stays set until reset or clear.
- pending never wraps; it never underflows because it only decrements when nonzero.
- Back-to-back blinks: cycle period is HOLD_CYCLES+GAP_CYCLES; there are no idle cycles between a GAP and the next ON.
- Reset asserted mid-blink: out drops to 0 immediately (asynchronously); pending and overflow are lost.

Test Plan (bench parameters HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2):
- Single event: in pulse at edge 10 -> out=1 on edges 11-14, out=0 on 15-16, busy=0 from edge 17; pending stays 0.
- Queued events: pulses at edges 10, 12, 13 -> blinks start at edges 11, 17 and 23; pending goes 0→1→2, then 1 at edge 17 and 0 at edge 23; overflow=0.
- Overflow: five pulses on edges 10-14 -> the first is consumed; pending saturates at 3 after edge 13; the edge-14 pulse is dropped and overflow=1; exactly four blinks follow.
- Simultaneous in at launch: pending=1 and in=1 on the last GAP cycle -> next blink starts and pending stays 1.
- Clear mid-blink: clear at edge 12 with pending=2 -> out=0, pending=0, overflow=0, busy=0 at edge 12; a new in afterwards blinks normally.
- Async reset: reset low during ON -> out=0 without waiting for a clock edge; after release, all outputs read 0 and no blink occurs until the next in.

Source files
------------

// File: rtl/led_pulse_stretch.sv
// LED pulse stretcher: turns single-cycle event strobes into visible blinks with a
// fixed dark gap between them, queuing events that arrive during a blink or gap.
module led_pulse_stretch #(
  parameter int HOLD_CYCLES = 16,
  parameter int GAP_CYCLES  = 8,
  parameter int CNT_W       = 5,
  parameter int PEND_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in,
  input  logic              clear,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  state_t            r_state, w_state_next;
  logic [CNT_W-1:0]  r_timer, w_timer_next;
  logic [PEND_W-1:0] r_pending, w_pending_next;
  logic              r_out, w_out_next;
  logic              r_overflow, w_overflow_next;
  logic              w_want;
  logic              w_launch;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_timer    <= '0;
      r_pending  <= '0;
      r_out      <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_timer    <= w_timer_next;
      r_pending  <= w_pending_next;
      r_out      <= w_out_next;
      r_overflow <= w_overflow_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_timer_next    = r_timer;
    w_pending_next  = r_pending;
    w_overflow_next = r_overflow;
    w_launch        = 1'b0;
    w_want          = in || (r_pending != '0);

    case (r_state)
      IDLE: begin
        if (w_want) begin
          w_state_next = ON;
          w_timer_next = HOLD_LOAD;
          w_launch     = 1'b1;
        end
      end
      ON: begin
        if (r_timer == '0) begin
          w_state_next = GAP;
          w_timer_next = GAP_LOAD;
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end
      GAP: begin
        if (r_timer == '0) begin
          if (w_want) begin
            w_state_next = ON;
            w_timer_next = HOLD_LOAD;
            w_launch     = 1'b1;
          end else begin
            w_state_next = IDLE;
            w_timer_next = '0;
          end
        end else begin
          w_timer_next = r_timer - CNT_W'(1);
        end
      end
      default: begin
        w_state_next = IDLE;
        w_timer_next = '0;
      end
    endcase

    // A launch drains the queue first; an in arriving with it simply takes its place.
    if (w_launch) begin
      if ((r_pending != '0) && !in) begin
        w_pending_next = r_pending - PEND_W'(1);
      end
    end else if (in) begin
      if (r_pending == PEND_MAX) begin
        w_overflow_next = 1'b1;
      end else begin
        w_pending_next = r_pending + PEND_W'(1);
      end
    end

    if (clear) begin
      w_state_next    = IDLE;
      w_timer_next    = '0;
      w_pending_next  = '0;
      w_overflow_next = 1'b0;
    end

    w_out_next = (w_state_next == ON);
  end

  assign out      = r_out;
  assign busy     = (r_state != IDLE);
  assign pending  = r_pending;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_led_pulse_stretch.sv
// Self-checking bench for led_pulse_stretch: run-length vector table plus a
// scoreboard queue checked on the falling clock edge, and an async-reset sequence.
module tb_led_pulse_stretch;

  localparam int HOLD = 4;
  localparam int GAPC = 2;
  localparam int PW   = 2;

  logic          clock;
  logic          reset;
  logic          in_s;
  logic          clear_s;
  logic          out_s;
  logic          busy_s;
  logic [PW-1:0] pending_s;
  logic          overflow_s;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic       vin;
    logic       vclr;
    logic [4:0] exp;   // {out, busy, pending[1:0], overflow}
    int         n;
    string      name;
  } vec_t;

  typedef struct {
    logic [4:0] exp;
    string      name;
  } sb_t;

  vec_t vecs[$];
  sb_t  exp_q[$];

  led_pulse_stretch #(
    .HOLD_CYCLES(HOLD),
    .GAP_CYCLES (GAPC),
    .CNT_W      (5),
    .PEND_W     (PW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .in      (in_s),
    .clear   (clear_s),
    .out     (out_s),
    .busy    (busy_s),
    .pending (pending_s),
    .overflow(overflow_s)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [4:0] ev(input logic o, input logic b, input int p, input logic ov);
    logic [1:0] pp;
    pp = 2'(p);
    return {o, b, pp, ov};
  endfunction

  task automatic add(input logic i, input logic c, input logic o, input logic b,
                     input int p, input logic ov, input int n, input string nm);
    vec_t v;
    v.vin  = i;
    v.vclr = c;
    v.exp  = ev(o, b, p, ov);
    v.n    = n;
    v.name = nm;
    vecs.push_back(v);
  endtask

  task automatic step(input logic i, input logic c, input logic [4:0] e, input string nm);
    sb_t s;
    @(negedge clock);
    #1;
    in_s    = i;
    clear_s = c;
    s.exp   = e;
    s.name  = nm;
    exp_q.push_back(s);
  endtask

  task automatic check_now(input string nm, input logic [4:0] e);
    logic [4:0] act;
    act = {out_s, busy_s, pending_s, overflow_s};
    tests_run++;
    if (act !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s: got out/busy/pend/ovf=%b, want %b", nm, act, e);
    end else begin
      $display("[TB] ok   %s: out/busy/pend/ovf=%b", nm, act);
    end
  endtask

  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      sb_t s;
      s = exp_q.pop_front();
      check_now(s.name, s.exp);
    end
  end

  initial begin
    reset   = 1'b0;
    in_s    = 1'b0;
    clear_s = 1'b0;

    add(1,0, 1,1,0,0, 1, "single");
    add(0,0, 1,1,0,0, 3, "single");
    add(0,0, 0,1,0,0, 2, "single");
    add(0,0, 0,0,0,0, 2, "single");

    add(1,0, 1,1,0,0, 1, "queued");
    add(0,0, 1,1,0,0, 1, "queued");
    add(1,0, 1,1,1,0, 1, "queued");
    add(1,0, 1,1,2,0, 1, "queued");
    add(0,0, 0,1,2,0, 2, "queued");
    add(0,0, 1,1,1,0, 4, "queued");
    add(0,0, 0,1,1,0, 2, "queued");
    add(0,0, 1,1,0,0, 4, "queued");
    add(0,0, 0,1,0,0, 2, "queued");
    add(0,0, 0,0,0,0, 1, "queued");

    add(1,0, 1,1,0,0, 1, "overflow");
    add(1,0, 1,1,1,0, 1, "overflow");
    add(1,0, 1,1,2,0, 1, "overflow");
    add(1,0, 1,1,3,0, 1, "overflow");
    add(1,0, 0,1,3,1, 1, "overflow");
    add(0,0, 0,1,3,1, 1, "overflow");
    add(0,0, 1,1,2,1, 4, "overflow");
    add(0,0, 0,1,2,1, 2, "overflow");
    add(0,0, 1,1,1,1, 4, "overflow");
    add(0,0, 0,1,1,1, 2, "overflow");
    add(0,0, 1,1,0,1, 4, "overflow");
    add(0,0, 0,1,0,1, 2, "overflow");
    add(0,0, 0,0,0,1, 2, "overflow");
    add(0,1, 0,0,0,0, 1, "clear_idle");

    add(1,0, 1,1,0,0, 1, "simul_launch");
    add(1,0, 1,1,1,0, 1, "simul_launch");
    add(0,0, 1,1,1,0, 2, "simul_launch");
    add(0,0, 0,1,1,0, 2, "simul_launch");
    add(1,0, 1,1,1,0, 1, "simul_launch");
    add(0,0, 1,1,1,0, 3, "simul_launch");
    add(0,0, 0,1,1,0, 2, "simul_launch");
    add(0,0, 1,1,0,0, 4, "simul_launch");
    add(0,0, 0,1,0,0, 2, "simul_launch");
    add(0,0, 0,0,0,0, 1, "simul_launch");

    add(1,0, 1,1,0,0, 1, "clear_blink");
    add(1,0, 1,1,1,0, 1, "clear_blink");
    add(1,0, 1,1,2,0, 1, "clear_blink");
    add(1,1, 0,0,0,0, 1, "clear_blink");
    add(0,0, 0,0,0,0, 1, "clear_blink");
    add(1,0, 1,1,0,0, 1, "clear_blink");
    add(0,0, 1,1,0,0, 3, "clear_blink");
    add(0,0, 0,1,0,0, 2, "clear_blink");
    add(0,0, 0,0,0,0, 1, "clear_blink");

    repeat (2) @(posedge clock);
    #2;
    check_now("reset_hold", 5'b00000);
    @(negedge clock);
    #1;
    reset = 1'b1;

    foreach (vecs[k]) begin
      for (int r = 0; r < vecs[k].n; r++) begin
        step(vecs[k].vin, vecs[k].vclr, vecs[k].exp, vecs[k].name);
      end
    end

    // Async reset mid-blink with an event queued.
    step(1, 0, ev(1,1,0,0), "async_pre");
    step(1, 0, ev(1,1,1,0), "async_pre");
    @(negedge clock);
    #2;
    in_s  = 1'b0;
    reset = 1'b0;
    #1;
    check_now("async_reset_now", 5'b00000);
    @(negedge clock);
    #1;
    reset = 1'b1;
    step(0, 0, ev(0,0,0,0), "async_after");
    step(0, 0, ev(0,0,0,0), "async_after");
    step(0, 0, ev(0,0,0,0), "async_after");
    step(1, 0, ev(1,1,0,0), "async_relaunch");
    step(0, 0, ev(1,1,0,0), "async_relaunch");
    @(negedge clock);
    #1;
    in_s = 1'b0;
    repeat (2) @(negedge clock);
    #1;

    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
